input_edge_tracker: RTL
=======================

# input_edge_tracker

Downstream consumer of the input bit shifter. It filters each channel's sample history into a stable level and flags rising and falling edges. It measures rise-to-rise periods in sample strobes and presents each measurement on one shared valid/ready event port. It sits between the input sampling chain and the clock-recovery / frequency-estimation logic.

## Interface
- `CHANNELS`, 4: number of input channels (matches upstream shifter depth)
- `HISTORY`, 4: samples of history per channel (matches upstream shifter width), ≥2
- `PERIOD_WIDTH`, 16: width of period counters and reported period
- `clk` input 1: system clock
- `async_rst` input 1: reset, asynchronous, active-high
- `clk_en` input 1: clock enable; gates all sampling/filter/counter state
- `clear_en_i` input 1: synchronous clear of all channel state (qualified by `clk_en`)
- `history_valid_i` input 1: strobe, `history_i` was updated this cycle (qualified by `clk_en`)
- `history_i` input CHANNELS×HISTORY: per-channel history, bit 0 newest sample
- `level_o` output CHANNELS: filtered level per channel
- `rise_o` output CHANNELS: one-cycle rising-edge pulse per channel
- `fall_o` output CHANNELS: one-cycle falling-edge pulse per channel
- `overrun_o` output CHANNELS: sticky, a pending measurement was overwritten
- `event_valid_o` output 1: measurement available
- `event_ready_i` input 1: consumer accepts measurement
- `event_channel_o` output $clog2(CHANNELS): channel of measurement
- `event_period_o` output PERIOD_WIDTH: strobes between consecutive rising edges

## Operation
- Strobe = `clk_en && history_valid_i`. All per-channel state updates only on a strobe, except the clear and the output handshake.
- Filter: level goes to 1 when all HISTORY bits are 1 and to 0 when all are 0. Otherwise the level holds.
- Edge: a 0→1 level change pulses `rise_o[c]`. A 1→0 change pulses `fall_o[c]`. Outside those cycles `rise_o` and `fall_o` are 0.
- Per channel there are three registers: `armed`, `count`, and `pending` + captured period.
- First rise after reset/clear: sets `armed`, `count`←0, no measurement.
- Strobe while armed, no rise: `count` increments, saturating at 2^PERIOD_WIDTH−1.
- Rise while armed: captured ← min(`count`+1, max); `count`←0; `pending`←1.
  - Example: rises on strobes 0 and 5 → period 5.
- Capture while `pending` is already set and not being granted: overwrite the captured value and set `overrun_o[c]`.
- Arbiter: round-robin over pending channels. The pointer resets to 0. After a grant to channel k, channel k+1 mod CHANNELS has highest priority.
- Output register: loaded with the winner when `!event_valid_o || event_ready_i`. The winner's `pending` clears in the same cycle.
- Capture and grant on the same channel in the same cycle: the grant takes the old value, the new capture sets `pending` again, no overrun.
- Handshake: `event_valid_o` stays high and the payload is stable until `event_ready_i`. The handshake runs every clock regardless of `clk_en`.
- Clear (`clk_en && clear_en_i`): `level`, `armed`, `count`, `pending`, `overrun` ← 0. The output register and arbiter pointer are untouched.
  - Clear has priority over a simultaneous strobe. A strobe in the clear cycle is ignored.

## Timing
- Reset values: `level_o`, `rise_o`, `fall_o`, `overrun_o`, `event_valid_o` = 0; `event_channel_o`, `event_period_o` = 0.
- Strobe in cycle N → `level_o` / `rise_o` / `fall_o` update in N+1. `pending` is set in N+1.
- Earliest `event_valid_o` is N+2. Full throughput is one event per cycle while `event_ready_i` is high.
- `async_rst` asserted mid-operation: all state clears immediately. Deassertion is synchronised externally.
- `clk_en` low: strobes and clear are ignored. Pulses already asserted drop after one cycle.

## Test plan
- Channel 0 history 0000→1111→0000 on three strobes → `level_o[0]` 0→1→0; `rise_o[0]` in strobe2+1; `fall_o[0]` in strobe3+1; history 0101 holds the level.
- Rises on strobes 0, 5, 12 with `event_ready_i`=1 → first rise gives no event; events report period 5 then 7, channel 0.
- 20 strobes with no rise after arming, PERIOD_WIDTH=4 → next rise reports 15 (saturated).
- Simultaneous rises on channels 0, 1, 3 with `event_ready_i`=0, then ready → events in order 0, 1, 3; next round starts priority at channel 0+.
- Two captures on channel 2 while `event_ready_i`=0 → `overrun_o[2]`=1; one event with the second period.
- `clear_en_i` with a strobe in the same cycle, then `async_rst` mid-count → clear: level/count/pending/overrun 0, strobe ignored; reset: all outputs 0 immediately, next rise only arms.

Source files
------------

// File: rtl/input_edge_tracker.sv
// Per-channel level filter and edge detector with rise-to-rise period measurement.
// Measurements from all channels share one round-robin arbitrated valid/ready event port.
module input_edge_tracker #(
    parameter int CHANNELS     = 4,
    parameter int HISTORY      = 4,
    parameter int PERIOD_WIDTH = 16,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         async_rst,
    input  logic                         clk_en,
    input  logic                         clear_en_i,
    input  logic                         history_valid_i,
    input  logic [CHANNELS*HISTORY-1:0]  history_i,
    output logic [CHANNELS-1:0]          level_o,
    output logic [CHANNELS-1:0]          rise_o,
    output logic [CHANNELS-1:0]          fall_o,
    output logic [CHANNELS-1:0]          overrun_o,
    output logic                         event_valid_o,
    input  logic                         event_ready_i,
    output logic [CH_W-1:0]              event_channel_o,
    output logic [PERIOD_WIDTH-1:0]      event_period_o
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

    logic strobe;
    logic clear;
    assign strobe = clk_en && history_valid_i;
    assign clear  = clk_en && clear_en_i;

    logic [CHANNELS-1:0]     pending_vec;
    logic [CHANNELS-1:0]     grant_vec;
    logic [PERIOD_WIDTH-1:0] captured_arr [CHANNELS];

    logic                    event_valid_reg;
    logic [CH_W-1:0]         event_channel_reg;
    logic [PERIOD_WIDTH-1:0] event_period_reg;
    logic [CH_W-1:0]         ptr_reg;
    logic [CH_W-1:0]         ptr_next;

    logic            load;
    logic            found;
    logic [CH_W-1:0] winner;
    logic [CH_W-1:0] cand;
    logic            grant_any;

    assign load      = !event_valid_reg || event_ready_i;
    assign grant_any = load && found;

    // First pending channel at or after the pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = CH_W'((int'(ptr_reg) + i) % CHANNELS);
            if (!found && pending_vec[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign ptr_next = (winner == CH_W'(CHANNELS - 1)) ? '0 : winner + CH_W'(1);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            event_valid_reg   <= 1'b0;
            event_channel_reg <= '0;
            event_period_reg  <= '0;
            ptr_reg           <= '0;
        end else if (load) begin
            event_valid_reg <= found;
            if (found) begin
                event_channel_reg <= winner;
                event_period_reg  <= captured_arr[winner];
                ptr_reg           <= ptr_next;
            end
        end
    end

    assign event_valid_o   = event_valid_reg;
    assign event_channel_o = event_channel_reg;
    assign event_period_o  = event_period_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [HISTORY-1:0]      hist;
        logic                    all_ones;
        logic                    all_zeros;
        logic                    level_reg;
        logic                    level_next;
        logic                    rise_next;
        logic                    fall_next;
        logic                    rise_reg;
        logic                    fall_reg;
        logic                    armed_reg;
        logic                    pending_reg;
        logic                    overrun_reg;
        logic                    capture;
        logic [PERIOD_WIDTH-1:0] count_reg;
        logic [PERIOD_WIDTH-1:0] count_inc;
        logic [PERIOD_WIDTH-1:0] captured_reg;

        assign hist       = history_i[gi*HISTORY +: HISTORY];
        assign all_ones   = &hist;
        assign all_zeros  = ~|hist;
        assign level_next = all_ones ? 1'b1 : (all_zeros ? 1'b0 : level_reg);
        assign rise_next  = strobe && !clear && !level_reg && level_next;
        assign fall_next  = strobe && !clear && level_reg && !level_next;
        assign capture    = rise_next && armed_reg;
        assign count_inc  = (count_reg == PERIOD_MAX) ? PERIOD_MAX
                                                      : count_reg + PERIOD_WIDTH'(1);
        assign grant_vec[gi] = grant_any && (winner == CH_W'(gi));

        always_ff @(posedge clk or posedge async_rst) begin
            if (async_rst) begin
                level_reg    <= 1'b0;
                rise_reg     <= 1'b0;
                fall_reg     <= 1'b0;
                armed_reg    <= 1'b0;
                pending_reg  <= 1'b0;
                overrun_reg  <= 1'b0;
                count_reg    <= '0;
                captured_reg <= '0;
            end else begin
                rise_reg <= rise_next;
                fall_reg <= fall_next;
                if (clear) begin
                    level_reg   <= 1'b0;
                    armed_reg   <= 1'b0;
                    count_reg   <= '0;
                    pending_reg <= 1'b0;
                    overrun_reg <= 1'b0;
                end else begin
                    if (strobe) begin
                        level_reg <= level_next;
                        if (rise_next) begin
                            armed_reg <= 1'b1;
                            count_reg <= '0;
                            if (armed_reg) begin
                                captured_reg <= count_inc;
                            end
                        end else if (armed_reg) begin
                            count_reg <= count_inc;
                        end
                    end
                    // A capture racing its own grant re-arms pending; the grant took the old value.
                    if (capture) begin
                        pending_reg <= 1'b1;
                        if (pending_reg && !grant_vec[gi]) begin
                            overrun_reg <= 1'b1;
                        end
                    end else if (grant_vec[gi]) begin
                        pending_reg <= 1'b0;
                    end
                end
            end
        end

        assign level_o[gi]      = level_reg;
        assign rise_o[gi]       = rise_reg;
        assign fall_o[gi]       = fall_reg;
        assign overrun_o[gi]    = overrun_reg;
        assign pending_vec[gi]  = pending_reg;
        assign captured_arr[gi] = captured_reg;
    end

endmodule
